// File: rtl/shiftcorr_pipe_pkg.sv
// Shared FPU post-processing configuration for the shift-correction pipe.
// Default sizes, Op encodings and the default-configuration payload bundle.
package shiftcorr_pipe_pkg;

  localparam int NE_DFLT          = 8;
  localparam int NORMSHIFTSZ_DFLT = 16;
  localparam int LZAERR           = 1;
  localparam int CORRSHIFTSZ      = NORMSHIFTSZ_DFLT - 1 - LZAERR;
  localparam int STAGES           = 1;
  localparam int TAGW_DFLT        = 4;

  localparam logic [1:0] OP_OTHER = 2'b00;
  localparam logic [1:0] OP_FMA   = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;

  typedef struct packed {
    logic [CORRSHIFTSZ-1:0] Mf;
    logic [NE_DFLT+1:0]     FmaMe;
    logic [NE_DFLT+1:0]     Ue;
    logic [1:0]             CorrAmt;
    logic                   Sticky;
    logic [TAGW_DFLT-1:0]   Tag;
  } payload_t;

endpackage

// File: rtl/shiftcorr_pipe_if.sv
// Input/output bundle of the shift-correction pipe with its handshakes.
// master drives payload in and takes results; slave is the pipe.
interface shiftcorr_pipe_if #(
  parameter int NE   = 8,
  parameter int W    = 16,
  parameter int C    = 14,
  parameter int TAGW = 4
);
  logic            Flush;
  logic            InValid;
  logic            InReady;
  logic [W-1:0]    Shifted;
  logic [1:0]      Op;
  logic            DivResSubnorm;
  logic [NE+1:0]   DivUe;
  logic            DivSubnormShiftPos;
  logic [NE+1:0]   NormSumExp;
  logic            FmaPreResultSubnorm;
  logic            FmaSZero;
  logic [TAGW-1:0] InTag;
  logic            OutValid;
  logic            OutReady;
  logic [C-1:0]    Mf;
  logic [NE+1:0]   FmaMe;
  logic [NE+1:0]   Ue;
  logic [1:0]      CorrAmt;
  logic            Sticky;
  logic [TAGW-1:0] OutTag;

  modport master (
    output Flush, InValid, Shifted, Op,
    output DivResSubnorm, DivUe,
    output DivSubnormShiftPos, NormSumExp,
    output FmaPreResultSubnorm, FmaSZero,
    output InTag, OutReady,
    input  InReady, OutValid, Mf, FmaMe,
    input  Ue, CorrAmt, Sticky, OutTag
  );

  modport slave (
    input  Flush, InValid, Shifted, Op,
    input  DivResSubnorm, DivUe,
    input  DivSubnormShiftPos, NormSumExp,
    input  FmaPreResultSubnorm, FmaSZero,
    input  InTag, OutReady,
    output InReady, OutValid, Mf, FmaMe,
    output Ue, CorrAmt, Sticky, OutTag
  );
endinterface

// File: rtl/shiftcorr_pipe_stage.sv
// One valid/ready payload register with flush.
// Payload only moves on a real transfer, so stalled data stays stable.
module shiftcorr_stage
  import shiftcorr_pipe_pkg::*;
#(
  parameter type T = payload_t
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  input  logic inValid,
  output logic inReady,
  input  T     inData,
  output logic outValid,
  input  logic outReady,
  output T     outData
);

  logic v;
  T     d;

  assign inReady  = ~v | outReady;
  assign outValid = v;
  assign outData  = d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (flush)
        v <= 1'b0;
      else if (inReady)
        v <= inValid;
      if (inValid & inReady & ~flush)
        d <= inData;
    end
  end

endmodule

// File: rtl/shiftcorr_pipe.sv
// FPU post-processing shift correction: LZA overshoot fix, divsqrt
// normalisation fix, and a STAGES-deep valid/ready register pipe.
module shiftcorr_pipe
  import shiftcorr_pipe_pkg::*;
#(
  parameter int NE          = 8,
  parameter int NORMSHIFTSZ = 16,
  parameter int LZAERR      = 1,
  parameter int CORRSHIFTSZ = NORMSHIFTSZ - 1 - LZAERR,
  parameter int STAGES      = 1,
  parameter int TAGW        = 4
) (
  input logic             clk,
  input logic             resetn,
  shiftcorr_pipe_if.slave bus
);

  localparam int W  = NORMSHIFTSZ;
  localparam int C  = CORRSHIFTSZ;
  localparam int NX = NE + 2;

  typedef struct packed {
    logic [C-1:0]    Mf;
    logic [NX-1:0]   FmaMe;
    logic [NX-1:0]   Ue;
    logic [1:0]      CorrAmt;
    logic            Sticky;
    logic [TAGW-1:0] Tag;
  } stage_t;

  logic [1:0]    k;
  logic          isFma;
  logic          isDiv;
  logic          resSubnorm;
  logic          leftShiftQm;
  logic          sticky;
  logic [W-1:0]  fmaShift;
  logic [W-1:0]  divShift;
  logic [W-1:0]  stMask;
  logic [C-1:0]  mf;
  logic [NX-1:0] fmaMe;
  logic [NX-1:0] ue;
  stage_t        inData;

  always_comb begin
    k = 2'd0;
    if (LZAERR == 2) begin
      if (bus.Shifted[W-1])
        k = 2'd2;
      else if (bus.Shifted[W-2])
        k = 2'd1;
    end else if (bus.Shifted[W-1]) begin
      k = 2'd1;
    end

    isFma = (bus.Op == OP_FMA);
    isDiv = (bus.Op == OP_DIV);

    fmaShift   = bus.Shifted >> k;
    resSubnorm = bus.FmaPreResultSubnorm &
                 ~|bus.Shifted[W-1 -: LZAERR+1];
    fmaMe = bus.NormSumExp + NX'(k) +
            NX'(bus.FmaPreResultSubnorm);
    if (bus.FmaSZero | resSubnorm)
      fmaMe = '0;

    // Bits pushed below the LSB by the LZA fix feed rounding.
    stMask = (W'(1) << k) - W'(1);
    sticky = isFma & |(bus.Shifted & stMask);

    leftShiftQm = bus.Shifted[W-1] |
                  (bus.DivUe == NX'(1));
    divShift = leftShiftQm ? (bus.Shifted >> (W-1-C))
                           : (bus.Shifted >> (W-2-C));

    unique case (1'b1)
      isFma:                      mf = fmaShift[C-1:0];
      isDiv & ~bus.DivResSubnorm: mf = divShift[C-1:0];
      default:                    mf = bus.Shifted[W-1 -: C];
    endcase

    if (bus.DivResSubnorm & bus.DivSubnormShiftPos)
      ue = '0;
    else
      ue = bus.DivUe -
           {{(NX-1){1'b0}}, ~bus.Shifted[W-1]};

    inData.Mf      = mf;
    inData.FmaMe   = fmaMe;
    inData.Ue      = ue;
    inData.CorrAmt = isFma ? k : 2'd0;
    inData.Sticky  = sticky;
    inData.Tag     = bus.InTag;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g
    logic   inV;
    logic   inR;
    logic   outV;
    logic   outR;
    stage_t inD;
    stage_t outD;

    if (i == 0) begin : head
      assign inV         = bus.InValid;
      assign inD         = inData;
      assign bus.InReady = inR;
    end else begin : body
      assign inV = g[i-1].outV;
      assign inD = g[i-1].outD;
    end

    if (i == STAGES - 1) begin : tail
      assign outR = bus.OutReady;
    end else begin : link
      assign outR = g[i+1].inR;
    end

    shiftcorr_stage #(.T(stage_t)) u_stage (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (bus.Flush),
      .inValid  (inV),
      .inReady  (inR),
      .inData   (inD),
      .outValid (outV),
      .outReady (outR),
      .outData  (outD)
    );
  end

  assign bus.OutValid = g[STAGES-1].outV;
  assign bus.Mf       = g[STAGES-1].outD.Mf;
  assign bus.FmaMe    = g[STAGES-1].outD.FmaMe;
  assign bus.Ue       = g[STAGES-1].outD.Ue;
  assign bus.CorrAmt  = g[STAGES-1].outD.CorrAmt;
  assign bus.Sticky   = g[STAGES-1].outD.Sticky;
  assign bus.OutTag   = g[STAGES-1].outD.Tag;

endmodule
